// File: rtl/booth_divider_if.sv
// Start/result handshake bundle for the sequential signed divider.
interface booth_divider_if #(
    parameter int unsigned size = 8
);
    logic                  start;
    logic [2*size-1:0]     dividend;
    logic [size-1:0]       divisor;
    logic [size-1:0]       quotient;
    logic [size-1:0]       remainder;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic                  div_by_zero;

    // Requester side: issues operands, observes results.
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, overflow, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, overflow, div_by_zero
    );
endinterface

// File: rtl/booth_divider.sv
// Sequential signed divider: 2N-bit dividend by N-bit divisor, one restoring
// step per clock on operand magnitudes, sign fix-up in a final cycle.
module booth_divider #(
    parameter int unsigned size = 8
) (
    input logic            clk,
    input logic            rst,
    booth_divider_if.slave bus
);
    localparam int unsigned W2   = 2 * size;
    localparam int unsigned CntW = $clog2(W2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    // Magnitude 2^(N-1): the largest quotient allowed when the result is negative.
    localparam logic [W2-1:0]   QLIM = W2'(1) << (size - 1);
    localparam logic [CntW-1:0] LAST = CntW'(W2 - 1);

    logic [1:0]      state_q, state_d;
    logic [W2-1:0]   dvd_q, dvd_d;      // dividend magnitude; quotient bits shift in at the LSB
    logic [size:0]   rem_q, rem_d;      // partial remainder
    logic [size-1:0] dvs_q, dvs_d;      // divisor magnitude
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            neg_dvd_q, neg_dvd_d;
    logic            neg_dvs_q, neg_dvs_d;
    logic            zero_q, zero_d;
    logic [size-1:0] quo_q, quo_d;
    logic [size-1:0] rmd_q, rmd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            dbz_q, dbz_d;

    logic [size:0]   rem_sh;
    logic [size+1:0] trial;
    logic            q_neg;
    logic [W2-1:0]   q_signed;
    logic [size-1:0] r_signed;

    // Trial subtraction for the current iteration and sign fix-up values.
    always_comb begin
        rem_sh   = {rem_q[size-1:0], dvd_q[W2-1]};
        trial    = {1'b0, rem_sh} - {2'b00, dvs_q};
        q_neg    = neg_dvd_q ^ neg_dvs_q;
        q_signed = q_neg ? (W2'(0) - dvd_q) : dvd_q;
        r_signed = neg_dvd_q ? (size'(0) - rem_q[size-1:0]) : rem_q[size-1:0];
    end

    // Next-state logic for the FSM and datapath.
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_dvd_d = neg_dvd_q;
        neg_dvs_d = neg_dvs_q;
        zero_d    = zero_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    neg_dvd_d = bus.dividend[W2-1];
                    neg_dvs_d = bus.divisor[size-1];
                    zero_d    = (bus.divisor == '0);
                    // Divide-by-zero reports the raw low dividend bits, so keep them unmodified.
                    if (bus.divisor == '0) begin
                        dvd_d = bus.dividend;
                    end else begin
                        dvd_d = bus.dividend[W2-1] ? (W2'(0) - bus.dividend) : bus.dividend;
                    end
                    dvs_d   = bus.divisor[size-1] ? (size'(0) - bus.divisor) : bus.divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                    state_d = (bus.divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (!trial[size+1]) begin
                    rem_d = trial[size:0];
                    dvd_d = {dvd_q[W2-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    dvd_d = {dvd_q[W2-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
                if (zero_q) begin
                    quo_d = '0;
                    rmd_d = dvd_q[size-1:0];
                    ovf_d = 1'b0;
                    dbz_d = 1'b1;
                end else begin
                    quo_d = q_signed[size-1:0];
                    rmd_d = r_signed;
                    ovf_d = q_neg ? (dvd_q > QLIM) : (dvd_q >= QLIM);
                    dbz_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            zero_q    <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_dvd_q <= neg_dvd_d;
            neg_dvs_q <= neg_dvs_d;
            zero_q    <= zero_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: directed vector table, corner-case
// sequences and randomized operations against an integer-arithmetic model.
module tb_booth_divider;
    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    booth_divider_if #(.size(N)) bus ();

    booth_divider #(.size(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2*N-1:0] dd;
        logic [N-1:0]   ds;
        logic [N-1:0]   q;
        logic [N-1:0]   r;
        logic           ovf;
        logic           dbz;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: plain signed integer division (truncating, remainder takes dividend sign).
    function automatic void model(input logic [2*N-1:0] dd, input logic [N-1:0] ds,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic ovf, output logic dbz);
        longint a, b, qq, rr;
        a = longint'($signed(dd));
        b = longint'($signed(ds));
        if (b == 0) begin
            q = '0; r = dd[N-1:0]; ovf = 1'b0; dbz = 1'b1;
        end else begin
            qq  = a / b;
            rr  = a % b;
            q   = qq[N-1:0];
            r   = rr[N-1:0];
            ovf = (qq < -(longint'(1) << (N - 1))) || (qq > (longint'(1) << (N - 1)) - 1);
            dbz = 1'b0;
        end
    endfunction

    // Present operands for one accepting edge, then scramble them.
    task automatic issue(input logic [2*N-1:0] dd, input logic [N-1:0] ds);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = ds;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = (2*N)'($urandom);
        bus.divisor  = N'($urandom);
    endtask

    // Counts cycles (accept edge = cycle 0) until done is seen, bounded.
    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (!bus.done && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string name, input logic [2*N-1:0] dd, input logic [N-1:0] ds,
                          input logic [N-1:0] eq, input logic [N-1:0] er,
                          input logic eo, input logic ez);
        int cyc;
        issue(dd, ds);
        chk({name, ".busy"}, 32'(bus.busy), 32'd1);
        wait_done(1, cyc);
        chk({name, ".latency"}, 32'(cyc), ez ? 32'd2 : 32'(2 * N + 2));
        chk({name, ".q"}, 32'(bus.quotient), 32'(eq));
        chk({name, ".r"}, 32'(bus.remainder), 32'(er));
        chk({name, ".ovf"}, 32'(bus.overflow), 32'(eo));
        chk({name, ".dbz"}, 32'(bus.div_by_zero), 32'(ez));
        chk({name, ".busy_at_done"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        chk({name, ".done_pulse"}, 32'(bus.done), 32'd0);
        chk({name, ".q_hold"}, 32'(bus.quotient), 32'(eq));
    endtask

    vec_t vecs[13];

    initial begin
        int cyc;
        int gap;
        logic seen;
        logic [2*N-1:0] rdd;
        logic [N-1:0]   rds, mq, mr;
        logic           mo, mz;
        logic [31:0]    x;

        vecs[0]  = '{16'hFFF1, 8'h05, 8'hFD, 8'h00, 1'b0, 1'b0};  // -15/5
        vecs[1]  = '{16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0};  // 100/-7
        vecs[2]  = '{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};  // -100/7
        vecs[3]  = '{16'h4000, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0};  // 16384/2
        vecs[4]  = '{16'hC080, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0};  // -16256/127
        vecs[5]  = '{16'h04D2, 8'h00, 8'h00, 8'hD2, 1'b0, 1'b1};  // 1234/0
        vecs[6]  = '{16'h004D, 8'hF8, 8'hF7, 8'h05, 1'b0, 1'b0};  // 77/-8
        vecs[7]  = '{16'h8000, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0};  // -32768/-128
        vecs[8]  = '{16'h8000, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0};  // -32768/1
        vecs[9]  = '{16'hFC00, 8'h08, 8'h80, 8'h00, 1'b0, 1'b0};  // -1024/8 = -128
        vecs[10] = '{16'h03F8, 8'h08, 8'h7F, 8'h00, 1'b0, 1'b0};  // 1016/8 = 127
        vecs[11] = '{16'h0400, 8'h08, 8'h80, 8'h00, 1'b1, 1'b0};  // 1024/8 = 128
        vecs[12] = '{16'hFFF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0};  // -7/2

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset.q", 32'(bus.quotient), 32'd0);
        chk("reset.r", 32'(bus.remainder), 32'd0);
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        chk("reset.ovf", 32'(bus.overflow), 32'd0);
        chk("reset.dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].dd, vecs[i].ds,
                   vecs[i].q, vecs[i].r, vecs[i].ovf, vecs[i].dbz);
        end

        // Second start while busy is ignored.
        issue(16'd100, 8'd7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor  = 8'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(4, cyc);
        chk("ignore.latency", 32'(cyc), 32'(2 * N + 2));
        chk("ignore.q", 32'(bus.quotient), 32'd14);
        chk("ignore.r", 32'(bus.remainder), 32'd2);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-operation discards the result.
        issue(16'd100, 8'd7);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst.q", 32'(bus.quotient), 32'd0);
        chk("midrst.r", 32'(bus.remainder), 32'd0);
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        chk("midrst.no_done", 32'(seen), 32'd0);
        run_op("after_rst", 16'd77, 8'hF8, 8'hF7, 8'h05, 1'b0, 1'b0);

        // Start held high: back-to-back operations every 2N+2 cycles.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor  = 8'd7;
        wait_done(0, cyc);
        chk("b2b.first_seen", 32'(bus.done), 32'd1);
        gap = 0;
        do begin
            @(posedge clk);
            #1;
            gap++;
        end while (!bus.done && gap < 60);
        bus.start = 1'b0;
        chk("b2b.period", 32'(gap), 32'(2 * N + 2));
        chk("b2b.q", 32'(bus.quotient), 32'd14);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b.idle", 32'(bus.busy), 32'd0);

        // Randomized operations against the integer model.
        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            rds = ($urandom_range(0, 7) == 0) ? N'(0) : N'($urandom);
            if ($urandom_range(0, 2) == 0) rdd = (2*N)'($urandom);
            else rdd = {{(2*N-10){x[9]}}, x[9:0]};
            model(rdd, rds, mq, mr, mo, mz);
            run_op($sformatf("rand%0d", i), rdd, rds, mq, mr, mo, mz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed divider: the inverse datapath of the team's Booth multiplier.
- Takes a 2*size-bit signed dividend (a product-width operand) and a size-bit signed divisor.
- Produces a size-bit quotient and remainder using one restoring iteration per clock.
- Sits beside the multiplier in the arithmetic unit and uses the same start/result style, plus a done/busy handshake.

Parameters:
- size, 8, operand width N. Dividend is 2N bits; divisor, quotient and remainder are N bits.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-low reset (clears the block while 0)
- start  input  1  request; sampled only in IDLE
- dividend  input  2*size  signed dividend; captured on the accepting edge
- divisor  input  size  signed divisor; captured on the accepting edge
- quotient  output  size  signed quotient, truncated toward zero
- remainder  output  size  signed remainder; sign follows the dividend
- busy  output  1  high from the accepting edge until done
- done  output  1  one-cycle pulse; results are valid from this cycle
- overflow  output  1  true quotient does not fit in signed N bits
- div_by_zero  output  1  divisor was 0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; quotient, remainder, busy, done, overflow and div_by_zero all 0. This applies mid-operation too: the operation is discarded with no done pulse.
- States:
  - IDLE -> CALC when start=1 and divisor!=0.
  - IDLE -> FIX when start=1 and divisor==0.
  - CALC -> FIX after 2N iterations.
  - FIX -> IDLE.
- Accepting edge (IDLE, start=1):
  - Latch the operand signs.
  - Load the unsigned magnitudes: 2N-bit dividend magnitude, N-bit divisor magnitude.
  - Clear the (N+1)-bit partial remainder; iteration counter = 0.
  - busy=1.
  - Clear done/overflow/div_by_zero at this edge.
- CALC, one edge per iteration, MSB first:
  - Shift {partial remainder, dividend magnitude} left 1.
  - Trial-subtract the divisor magnitude. If non-negative, keep the difference and set quotient bit 1; else restore and set quotient bit 0.
  - Exactly 2N CALC edges. The full 2N-bit magnitude quotient is kept internally.
- FIX edge:
  - Quotient is negated if the operand signs differ; remainder is negated if the dividend is negative.
  - overflow=1 if the signed 2N-bit quotient lies outside [-2^(N-1), 2^(N-1)-1]. quotient output = low N bits regardless.
  - The remainder always fits in N bits.
  - done=1, busy=0 in the following cycle.
- Divide by zero (FIX reached directly): div_by_zero=1, quotient=0, remainder=dividend[N-1:0], overflow=0.
- Latency:
  - Normal: done visible in cycle 2N+2 counted from the accepting edge (accept, 2N iterations, FIX). For N=8, done is high during the 18th cycle after start is sampled.
  - Divide by zero: done is visible after 2 edges.
- done lasts exactly one cycle. quotient, remainder and the flags hold until the next accepting edge.
- start while busy (CALC/FIX) is ignored, with no queuing.
- start held high continuously: a new operation is accepted on the first IDLE edge after done. Back-to-back operations therefore occur every 2N+2 cycles.
- Operand changes after the accepting edge have no effect.
- Extreme operands:
  - Most-negative dividend -2^(2N-1): magnitude 2^(2N-1) handled in 2N unsigned bits.
  - Divisor -2^(N-1): magnitude 2^(N-1) handled in N unsigned bits.
  - Quotient exactly -2^(N-1) is not overflow.
- Negation is two's complement.

Test Plan:
- dividend=-15 (16'hFFF1), divisor=5, start pulse -> done pulses once after 18 cycles; quotient=8'hFD (-3), remainder=0, overflow=0; busy high until done.
- 100/-7 -> quotient=8'hF2 (-14), remainder=2. Then -100/7 -> quotient=8'hF2, remainder=8'hFE (-2).
- 16384/2 -> overflow=1, quotient=8'h00, remainder=0. Then -16256/127 -> quotient=8'h80, overflow=0, remainder=0.
- 1234/0 -> done 2 edges after acceptance; div_by_zero=1, quotient=0, remainder=8'hD2, overflow=0.
- Start 100/7. Pulse start with 50/5 at cycle 4 -> second start ignored; result quotient=14, remainder=2.
- Start 100/7, drive rst=0 at cycle 6 -> all outputs 0 immediately and no done pulse. Release rst, start 77/-8 -> quotient=8'hF7 (-9), remainder=5.
